dbg_frame_tx: RTL and testbench
===============================

DBG_FRAME_TX -- requirements
Module: dbg_frame_tx

Interface
REQ-001 Parameter PERIOD, default 10000: clk cycles spent in IDLE between automatic snapshots; legal range 2..65535.
REQ-002 Parameter SYNC_BYTE, default 8'hA5: first byte of every frame.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 word_in  input  32  debug word to snapshot, e.g. a register-file debug tap.
REQ-006 trigger  input  1  one-cycle request for an immediate frame.
REQ-007 uart_tx_busy  input  1  busy flag from the UART transmitter.
REQ-008 uart_tx_en  output  1  one-cycle byte-send strobe to the UART transmitter.
REQ-009 uart_tx_data  output  8  byte presented with uart_tx_en.
REQ-010 frame_busy  output  1  high from snapshot until the last byte's WAIT exits.
REQ-011 frames_sent  output  16  count of completed frames; wraps 16'hFFFF -> 0.

Function
REQ-012 Frame: 6 bytes in order: SYNC_BYTE, word[7:0], word[15:8], word[23:16], word[31:24], CHK.
REQ-013 CHK: sum of the four data bytes modulo 256.
REQ-014 FSM states: IDLE, LOAD, SEND, HOLD, WAIT.
REQ-015 IDLE: timer increments each cycle; on timer==PERIOD-1, trigger==1, or pending==1, go to LOAD.
REQ-016 LOAD, 1 cycle: latch word_in into the snapshot register; compute CHK; set byte index 0; clear timer and pending.
REQ-017 SEND: when uart_tx_busy==0, drive uart_tx_en=1 for exactly one cycle with the indexed byte, then go to HOLD; while busy==1, remain in SEND with en=0.
REQ-018 HOLD, 1 cycle: ignore uart_tx_busy, covering the transmitter's one-cycle busy latency; go to WAIT.
REQ-019 WAIT: when uart_tx_busy==0, either increment the index and go to SEND if index<5, or increment frames_sent and go to IDLE if index==5.
REQ-020 Timer: counts only in IDLE; holds 0 outside IDLE; never exceeds PERIOD-1.
REQ-021 Snapshot: word_in changes after LOAD do not alter the frame in flight.
REQ-022 trigger outside IDLE: set a single pending flag; further triggers before service are merged; exactly one extra frame follows.
REQ-023 trigger coincident with timer expiry in IDLE: exactly one frame.
REQ-024 uart_tx_data: holds its last value when uart_tx_en==0.
REQ-025 Latency: trigger seen in IDLE at cycle N with busy low gives uart_tx_en at N+2, carrying SYNC_BYTE.
REQ-026 frame_busy: equals (state != IDLE).

Reset
REQ-027 rst asserted: state=IDLE, timer=0, pending=0, index=0, snapshot=0, uart_tx_en=0, uart_tx_data=8'h00, frame_busy=0, frames_sent=0; takes effect immediately without clk.
REQ-028 rst mid-frame: aborts the frame with no further strobes; frames_sent is not incremented.
REQ-029 After rst deasserts, the first automatic frame's LOAD occurs PERIOD cycles later.

Verification
REQ-030 Byte order: word_in=32'h12345678, trigger pulse, transmitter model busy for 20 cycles per byte -> bytes A5,78,56,34,12,14; frames_sent=1.
REQ-031 Automatic period: PERIOD=16, word_in=32'hFFFFFFFF, no trigger -> LOAD 16 cycles after reset; CHK=8'hFC; next LOAD 16 IDLE cycles after the frame ends.
REQ-032 Busy stall: busy held high 100 cycles before byte 3 -> no strobe during the stall; byte 3 (8'h34) sent on the first cycle busy is low; exactly one strobe per byte.
REQ-033 Pending merge: 3 trigger pulses during frame 1 -> exactly one follow-up frame; frames_sent=2.
REQ-034 Async reset: rst asserted between clk edges after byte 2 -> all outputs reach reset values before the next edge; no further uart_tx_en; frames_sent=0.
REQ-035 Snapshot stability: word_in changed from 32'h00000001 to 32'hDEADBEEF one cycle after LOAD -> frame carries 01,00,00,00, CHK 01.

Source files
------------

// File: rtl/dbg_frame_tx.sv
// dbg_frame_tx: sends a 6-byte debug frame (sync, 4 data bytes LSB first,
// additive checksum) over a byte-wide UART transmitter, either periodically
// or on demand via trigger.
module dbg_frame_tx #(
   parameter int unsigned PERIOD    = 10000,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] word_in,
   input  logic        trigger,
   input  logic        uart_tx_busy,
   output logic        uart_tx_en,
   output logic [7:0]  uart_tx_data,
   output logic        frame_busy,
   output logic [15:0] frames_sent
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND,
      HOLD,
      WAIT
   } state_t;

   localparam logic [15:0] TIMER_LAST = 16'(PERIOD - 1);
   localparam logic [2:0]  LAST_IDX   = 3'd5;

   state_t      state;
   logic [15:0] timer;
   logic        pending;
   logic [2:0]  idx;
   logic [31:0] snap;
   logic [7:0]  chk;
   logic [7:0]  cur_byte;
   logic [7:0]  word_sum;

   // Checksum of the live word; captured together with the snapshot in LOAD
   always_comb begin
      word_sum = word_in[7:0] + word_in[15:8] + word_in[23:16] + word_in[31:24];
   end

   // Frame byte addressed by the current index
   always_comb begin
      cur_byte = SYNC_BYTE;
      case (idx)
         3'd1:    cur_byte = snap[7:0];
         3'd2:    cur_byte = snap[15:8];
         3'd3:    cur_byte = snap[23:16];
         3'd4:    cur_byte = snap[31:24];
         3'd5:    cur_byte = chk;
         default: cur_byte = SYNC_BYTE;
      endcase
   end

   // Frame sequencer with registered strobe, data, busy flag and frame counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         timer        <= '0;
         pending      <= 1'b0;
         idx          <= '0;
         snap         <= '0;
         chk          <= '0;
         uart_tx_en   <= 1'b0;
         uart_tx_data <= '0;
         frame_busy   <= 1'b0;
         frames_sent  <= '0;
      end else begin
         uart_tx_en <= 1'b0;
         // Triggers arriving mid-frame collapse into one pending request;
         // LOAD handles its own cycle below.
         if (trigger && state != IDLE && state != LOAD)
            pending <= 1'b1;
         case (state)
            IDLE: begin
               if (timer == TIMER_LAST || trigger || pending) begin
                  state      <= LOAD;
                  frame_busy <= 1'b1;
                  timer      <= '0;
               end else begin
                  timer <= timer + 16'd1;
               end
            end
            LOAD: begin
               snap    <= word_in;
               chk     <= word_sum;
               idx     <= '0;
               timer   <= '0;
               // A trigger landing on the LOAD cycle still earns a follow-up frame
               pending <= trigger;
               state   <= SEND;
            end
            SEND: begin
               if (!uart_tx_busy) begin
                  uart_tx_en   <= 1'b1;
                  uart_tx_data <= cur_byte;
                  state        <= HOLD;
               end
            end
            HOLD: begin
               state <= WAIT;
            end
            WAIT: begin
               if (!uart_tx_busy) begin
                  if (idx < LAST_IDX) begin
                     idx   <= idx + 3'd1;
                     state <= SEND;
                  end else begin
                     frames_sent <= frames_sent + 16'd1;
                     frame_busy  <= 1'b0;
                     state       <= IDLE;
                  end
               end
            end
            default: begin
               state      <= IDLE;
               frame_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dbg_frame_tx.sv
// tb_dbg_frame_tx: table-driven, directed and randomized checks of dbg_frame_tx
// against a frame-level reference model and a simple UART transmitter model.
module tb_dbg_frame_tx;

   localparam int unsigned PER = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] word_in = '0;
   logic        trigger = 1'b0;
   logic        uart_tx_busy;
   logic        uart_tx_en;
   logic [7:0]  uart_tx_data;
   logic        frame_busy;
   logic [15:0] frames_sent;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dbg_frame_tx #(
      .PERIOD    (PER),
      .SYNC_BYTE (8'hA5)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .word_in      (word_in),
      .trigger      (trigger),
      .uart_tx_busy (uart_tx_busy),
      .uart_tx_en   (uart_tx_en),
      .uart_tx_data (uart_tx_data),
      .frame_busy   (frame_busy),
      .frames_sent  (frames_sent)
   );

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Reference frame: sync, data bytes LSB first, sum of data bytes mod 256
   function automatic logic [47:0] frame_of(logic [31:0] w);
      int s;
      s = int'(w[7:0]) + int'(w[15:8]) + int'(w[23:16]) + int'(w[31:24]);
      return {8'hA5, w[7:0], w[15:8], w[23:16], w[31:24], 8'(s % 256)};
   endfunction

   function automatic logic [7:0] byte_of(logic [47:0] f, int k);
      return f[47 - 8*k -: 8];
   endfunction

   // UART transmitter model: busy for busy_len cycles after each accepted strobe
   int   busy_len = 20;
   int   bcnt;
   logic mbusy;
   logic stall = 1'b0;
   assign uart_tx_busy = mbusy | stall;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mbusy <= 1'b0;
         bcnt  <= 0;
      end else if (uart_tx_en) begin
         mbusy <= 1'b1;
         bcnt  <= busy_len;
      end else if (bcnt > 1) begin
         bcnt <= bcnt - 1;
      end else begin
         bcnt  <= 0;
         mbusy <= 1'b0;
      end
   end

   // Byte monitor: logs strobed bytes, checks strobe protocol and, in random mode, content
   logic [7:0] rx[$];
   logic       prev_en = 1'b0;
   bit         rand_chk = 1'b0;

   always @(negedge clk) begin
      if (uart_tx_en) begin
         chk("strobe_while_busy", 32'(uart_tx_busy), 32'd0);
         chk("strobe_single_cycle", 32'(prev_en), 32'd0);
         if (rand_chk)
            chk("rand_byte", 32'(uart_tx_data), 32'(byte_of(frame_of(word_in), rx.size() % 6)));
         rx.push_back(uart_tx_data);
      end
      prev_en <= uart_tx_en;
   end

   typedef struct {
      logic [31:0] word;
      int          blen;
      logic [47:0] exp;
   } vec_t;

   vec_t vecs[5];

   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b1;
      trigger = 1'b0;
      stall   = 1'b0;
      repeat (2) @(negedge clk);
      rx.delete();
      rst = 1'b0;
   endtask

   task automatic pulse_trigger();
      @(negedge clk);
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
   endtask

   task automatic wait_bytes(int n, string name);
      int t = 0;
      while (rx.size() < n && t < 3000) begin
         @(posedge clk);
         #2;
         t++;
      end
      chk({name, "_bytes_timeout"}, 32'(rx.size() >= n), 32'd1);
   endtask

   task automatic wait_idle(string name);
      int t = 0;
      while (frame_busy && t < 3000) begin
         @(posedge clk);
         #2;
         t++;
      end
      chk({name, "_idle_timeout"}, 32'(frame_busy), 32'd0);
   endtask

   // Counts rising edges until frame_busy goes high (bounded)
   task automatic edges_to_load(output int n);
      n = 0;
      while (n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (frame_busy) break;
      end
   endtask

   task automatic check_frame(string name, int base, logic [47:0] f);
      for (int k = 0; k < 6; k++)
         chk(name, 32'(rx[base + k]), 32'(byte_of(f, k)));
   endtask

   initial begin
      int n;
      vecs[0] = '{32'h12345678, 20, 48'hA5_78_56_34_12_14};
      vecs[1] = '{32'hFFFFFFFF, 1,  48'hA5_FF_FF_FF_FF_FC};
      vecs[2] = '{32'h00000001, 3,  48'hA5_01_00_00_00_01};
      vecs[3] = '{32'hDEADBEEF, 20, 48'hA5_EF_BE_AD_DE_38};
      vecs[4] = '{32'h01020304, 5,  48'hA5_04_03_02_01_0A};

      // Reset applied before any clock edge
      #1 rst = 1'b1;
      #1;
      chk("reset_en", 32'(uart_tx_en), 32'd0);
      chk("reset_data", 32'(uart_tx_data), 32'd0);
      chk("reset_frame_busy", 32'(frame_busy), 32'd0);
      chk("reset_frames_sent", 32'(frames_sent), 32'd0);

      // Table: triggered frame per vector, latency, content and count
      for (int i = 0; i < 5; i++) begin
         busy_len = vecs[i].blen;
         word_in  = vecs[i].word;
         do_reset();
         pulse_trigger();
         chk("tab_busy_after_trigger", 32'(frame_busy), 32'd1);
         @(posedge clk); #1;
         chk("tab_en_load_cycle", 32'(uart_tx_en), 32'd0);
         @(posedge clk); #1;
         chk("tab_en_latency", 32'(uart_tx_en), 32'd1);
         chk("tab_first_byte", 32'(uart_tx_data), 32'h0000_00A5);
         wait_bytes(6, "tab");
         wait_idle("tab");
         check_frame("tab_frame", 0, vecs[i].exp);
         chk("tab_frames_sent", 32'(frames_sent), 32'd1);
         chk("tab_byte_count", 32'(rx.size()), 32'd6);
      end

      // Automatic period: first LOAD PER edges after reset, next PER idle cycles after frame end
      busy_len = 20;
      word_in  = 32'hFFFFFFFF;
      do_reset();
      edges_to_load(n);
      chk("auto_first_load", 32'(n), 32'(PER));
      wait_bytes(6, "auto");
      wait_idle("auto");
      check_frame("auto_frame", 0, 48'hA5_FF_FF_FF_FF_FC);
      edges_to_load(n);
      chk("auto_second_load", 32'(n), 32'(PER));

      // Busy stall before byte 3
      word_in = 32'h12345678;
      do_reset();
      pulse_trigger();
      wait_bytes(3, "stall");
      stall = 1'b1;
      repeat (100) @(posedge clk);
      chk("stall_no_strobe", 32'(rx.size()), 32'd3);
      #2 stall = 1'b0;
      @(posedge clk); #1;
      chk("stall_wait_exit", 32'(uart_tx_en), 32'd0);
      @(posedge clk); #1;
      chk("stall_resume_en", 32'(uart_tx_en), 32'd1);
      chk("stall_resume_data", 32'(uart_tx_data), 32'h34);
      wait_bytes(6, "stall");
      wait_idle("stall");
      check_frame("stall_frame", 0, 48'hA5_78_56_34_12_14);
      chk("stall_byte_count", 32'(rx.size()), 32'd6);
      chk("stall_frames_sent", 32'(frames_sent), 32'd1);

      // Pending merge: three triggers mid-frame give exactly one follow-up
      word_in = 32'h01020304;
      do_reset();
      pulse_trigger();
      wait_bytes(1, "merge");
      for (int k = 0; k < 3; k++) begin
         pulse_trigger();
         repeat (7) @(negedge clk);
      end
      wait_bytes(12, "merge");
      wait_idle("merge");
      chk("merge_frames_sent", 32'(frames_sent), 32'd2);
      check_frame("merge_frame2", 6, 48'hA5_04_03_02_01_0A);
      edges_to_load(n);
      chk("merge_no_third", 32'(n), 32'(PER));
      chk("merge_byte_count", 32'(rx.size()), 32'd12);

      // Asynchronous reset mid-frame
      word_in = 32'h12345678;
      do_reset();
      pulse_trigger();
      wait_bytes(6, "arst");
      wait_idle("arst");
      pulse_trigger();
      wait_bytes(9, "arst");
      chk("arst_pre_count", 32'(frames_sent), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("arst_en", 32'(uart_tx_en), 32'd0);
      chk("arst_data", 32'(uart_tx_data), 32'd0);
      chk("arst_frame_busy", 32'(frame_busy), 32'd0);
      chk("arst_frames_sent", 32'(frames_sent), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      n = rx.size();
      repeat (12) @(posedge clk);
      #1;
      chk("arst_no_more_strobes", 32'(rx.size()), 32'(n));
      chk("arst_count_after", 32'(frames_sent), 32'd0);

      // Snapshot stability: word changes the cycle after LOAD
      busy_len = 4;
      word_in  = 32'h00000001;
      do_reset();
      pulse_trigger();
      @(posedge clk);
      @(negedge clk);
      word_in = 32'hDEADBEEF;
      wait_bytes(6, "snap");
      wait_idle("snap");
      check_frame("snap_frame", 0, 48'hA5_01_00_00_00_01);

      // Randomized traffic: words change only while idle, random triggers and busy lengths
      busy_len = 3;
      do_reset();
      rand_chk = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         trigger = ($urandom_range(0, 19) == 0);
         if (!frame_busy && $urandom_range(0, 3) == 0)
            word_in = $urandom;
         if ($urandom_range(0, 99) == 0)
            busy_len = $urandom_range(1, 8);
      end
      @(negedge clk);
      trigger = 1'b0;
      wait_idle("rand");
      chk("rand_whole_frames", 32'(rx.size() % 6), 32'd0);
      chk("rand_frames_sent", 32'(frames_sent), 32'(rx.size() / 6));
      rand_chk = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
